// File: rtl/sha256_msg_feeder.sv
// SHA-256 message feeder: packs a byte stream into big-endian words, pads it and drives the
// compression core one 512-bit block at a time. Define SHA256_BLOCK_COUNT_EN for block_count_o.
module sha256_msg_feeder #(
   parameter int unsigned CNT_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_data_i,
   input  logic        in_valid_i,
   input  logic        in_last_i,
   output logic        in_ready_o,
   output logic        core_init_o,
   output logic        core_cs_o,
   output logic        core_wr_o,
   output logic [3:0]  core_addr_o,
   output logic [31:0] core_wdata_o,
   output logic        core_go_o,
   input  logic        core_done_i,
   output logic        busy_o,
`ifdef SHA256_BLOCK_COUNT_EN
   output logic [15:0] block_count_o,
`endif
   output logic        digest_valid_o
);

   typedef enum logic [2:0] {
      StIdle, StInit, StLoad, StPad, StGo, StWait0, StWait, StFin
   } state_e;

   state_e           state_q;
   logic [CNT_W-1:0] byte_cnt_q;
   logic [3:0]       word_idx_q;
   logic [1:0]       lane_q;
   logic [31:0]      word_q;
   logic             msg_done_q;   // final byte accepted
   logic             marker_q;     // 0x80 byte already written
   logic             extra_q;      // marker landed too late for the length in this block
   logic             len_done_q;   // length words written

   logic        accept;
   logic [31:0] acc_word;
   logic [31:0] marker_word;
   logic [31:0] pad_word;
   logic [63:0] msg_bits;

   assign accept    = in_valid_i & in_ready_o;
   assign core_cs_o = core_wr_o;

   always_comb begin
      acc_word = {word_q[23:0], in_data_i};
      msg_bits = 64'({byte_cnt_q, 3'b000});
      unique case (lane_q)
         2'd0:    marker_word = 32'h8000_0000;
         2'd1:    marker_word = {word_q[7:0], 24'h80_0000};
         2'd2:    marker_word = {word_q[15:0], 16'h8000};
         default: marker_word = {word_q[23:0], 8'h80};
      endcase
      if (!marker_q) begin
         pad_word = marker_word;
      end else if (!extra_q && word_idx_q == 4'd14) begin
         pad_word = msg_bits[63:32];
      end else if (!extra_q && word_idx_q == 4'd15) begin
         pad_word = msg_bits[31:0];
      end else begin
         pad_word = 32'h0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= StIdle;
         byte_cnt_q     <= '0;
         word_idx_q     <= 4'd0;
         lane_q         <= 2'd0;
         word_q         <= 32'h0;
         msg_done_q     <= 1'b0;
         marker_q       <= 1'b0;
         extra_q        <= 1'b0;
         len_done_q     <= 1'b0;
         in_ready_o     <= 1'b0;
         core_init_o    <= 1'b0;
         core_wr_o      <= 1'b0;
         core_addr_o    <= 4'd0;
         core_wdata_o   <= 32'h0;
         core_go_o      <= 1'b0;
         busy_o         <= 1'b0;
         digest_valid_o <= 1'b0;
`ifdef SHA256_BLOCK_COUNT_EN
         block_count_o  <= 16'd0;
`endif
      end else begin
         core_init_o    <= 1'b0;
         core_wr_o      <= 1'b0;
         core_go_o      <= 1'b0;
         digest_valid_o <= 1'b0;
         case (state_q)
            StIdle: begin
               if (in_valid_i) begin
                  state_q     <= StInit;
                  core_init_o <= 1'b1;
                  busy_o      <= 1'b1;
               end
            end
            StInit: begin
               byte_cnt_q <= '0;
               word_idx_q <= 4'd0;
               lane_q     <= 2'd0;
               word_q     <= 32'h0;
               msg_done_q <= 1'b0;
               marker_q   <= 1'b0;
               extra_q    <= 1'b0;
               len_done_q <= 1'b0;
               in_ready_o <= 1'b1;
               state_q    <= StLoad;
`ifdef SHA256_BLOCK_COUNT_EN
               block_count_o <= 16'd0;
`endif
            end
            StLoad: begin
               if (accept) begin
                  word_q     <= acc_word;
                  byte_cnt_q <= byte_cnt_q + 1'b1;
                  lane_q     <= lane_q + 2'd1;
                  if (in_last_i) begin
                     msg_done_q <= 1'b1;
                  end
                  if (lane_q == 2'd3) begin
                     core_wr_o    <= 1'b1;
                     core_addr_o  <= word_idx_q;
                     core_wdata_o <= acc_word;
                     word_idx_q   <= word_idx_q + 4'd1;
                  end
                  // A full block takes priority; padding then starts in the next block.
                  if (lane_q == 2'd3 && word_idx_q == 4'd15) begin
                     in_ready_o <= 1'b0;
                     state_q    <= StGo;
                  end else if (in_last_i) begin
                     in_ready_o <= 1'b0;
                     state_q    <= StPad;
                  end
               end
            end
            StPad: begin
               core_wr_o    <= 1'b1;
               core_addr_o  <= word_idx_q;
               core_wdata_o <= pad_word;
               word_idx_q   <= word_idx_q + 4'd1;
               if (!marker_q) begin
                  marker_q <= 1'b1;
                  if (word_idx_q >= 4'd14) begin
                     extra_q <= 1'b1;
                  end
               end
               if (word_idx_q == 4'd15) begin
                  state_q <= StGo;
                  if (marker_q && !extra_q) begin
                     len_done_q <= 1'b1;
                  end
               end
            end
            StGo: begin
               core_go_o <= 1'b1;
               state_q   <= StWait0;
`ifdef SHA256_BLOCK_COUNT_EN
               if (block_count_o != 16'hFFFF) begin
                  block_count_o <= block_count_o + 16'd1;
               end
`endif
            end
            StWait0: state_q <= StWait;
            StWait: begin
               if (core_done_i) begin
                  if (!msg_done_q) begin
                     in_ready_o <= 1'b1;
                     state_q    <= StLoad;
                  end else if (!len_done_q) begin
                     extra_q <= 1'b0;
                     state_q <= StPad;
                  end else begin
                     digest_valid_o <= 1'b1;
                     state_q        <= StFin;
                  end
               end
            end
            StFin: begin
               busy_o  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Bench for sha256_msg_feeder: behavioural SHA-256 core, padding reference model,
// table-driven vectors, reset abort sequence and randomized messages.
module tb_sha256_msg_feeder;

   localparam int LAT = 12;
   localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
      32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
      32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
      32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
      32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
      32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  in_data = 8'h0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready, core_init, core_cs, core_wr, core_go, busy, digest_valid;
   logic [3:0]  core_addr;
   logic [31:0] core_wdata;
   logic        core_done = 1'b1;
`ifdef SHA256_BLOCK_COUNT_EN
   logic [15:0] block_count;
`endif

   always #5 clk = ~clk;

   sha256_msg_feeder #(.CNT_W(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_data_i      (in_data),
      .in_valid_i     (in_valid),
      .in_last_i      (in_last),
      .in_ready_o     (in_ready),
      .core_init_o    (core_init),
      .core_cs_o      (core_cs),
      .core_wr_o      (core_wr),
      .core_addr_o    (core_addr),
      .core_wdata_o   (core_wdata),
      .core_go_o      (core_go),
      .core_done_i    (core_done),
      .busy_o         (busy),
`ifdef SHA256_BLOCK_COUNT_EN
      .block_count_o  (block_count),
`endif
      .digest_valid_o (digest_valid)
   );

   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
      for (int i = 16; i < 64; i++)
         w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7] +
                (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
      {a, b, c, d, e, f, g, h} = hin;
      for (int i = 0; i < 64; i++) begin
         t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
         t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
              hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
   endfunction

   // Behavioural core: done drops the cycle after go and returns LAT cycles later.
   logic [511:0] mem = '0;
   logic [255:0] core_h = '0;
   logic [35:0]  wr_log[$];
   int init_cnt = 0, go_cnt = 0, dv_cnt = 0, viol_cnt = 0, done_cnt = 0;

   always @(posedge clk) begin
      if (core_wr) begin
         wr_log.push_back({core_addr, core_wdata});
         mem[511 - 32*int'(core_addr) -: 32] <= core_wdata;
      end
      if (core_init) begin
         core_h   <= IV;
         init_cnt <= init_cnt + 1;
      end
      if (core_go) begin
         core_h    <= sha_compress(core_h, mem);
         go_cnt    <= go_cnt + 1;
         core_done <= 1'b0;
         done_cnt  <= LAT;
      end else if (done_cnt > 0) begin
         done_cnt <= done_cnt - 1;
         if (done_cnt == 1) core_done <= 1'b1;
      end
      if (digest_valid) dv_cnt <= dv_cnt + 1;
      if ((core_init && core_wr) || (core_cs != core_wr) || (core_wr && core_go))
         viol_cnt <= viol_cnt + 1;
   end

   task automatic chk_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   logic [7:0]  msg_q[$];
   logic [31:0] exp_w[$];

   // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
   task automatic build_expected();
      logic [7:0]  b[$];
      logic [63:0] bits;
      b = msg_q;
      b.push_back(8'h80);
      while (b.size() % 64 != 56) b.push_back(8'h00);
      bits = 64'(msg_q.size()) * 64'd8;
      for (int k = 7; k >= 0; k--) b.push_back(bits[8*k +: 8]);
      exp_w.delete();
      for (int i = 0; i < b.size(); i += 4) exp_w.push_back({b[i], b[i+1], b[i+2], b[i+3]});
   endtask

   task automatic send_bytes(input bit toggle, input int gap_max);
      int t;
      for (int i = 0; i < msg_q.size(); i++) begin
         in_data  = msg_q[i];
         in_last  = (i == msg_q.size() - 1);
         in_valid = 1'b1;
         t = 0;
         while (!in_ready && t < 400) begin
            @(posedge clk); #1; t++;
         end
         if (t >= 400) begin
            chk_int("byte accept", int'(in_ready), 1);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
         in_last  = 1'b0;
         if (toggle) begin
            @(posedge clk); #1;
         end else if (gap_max > 0) begin
            repeat ($urandom_range(gap_max)) begin
               @(posedge clk); #1;
            end
         end
      end
   endtask

   task automatic run_msg(input string tag, input bit toggle, input int gap_max,
                          input int exp_gos);
      int wr0, go0, in0, dv0, vi0, t, nw, nblk;
      logic [255:0] h;
      logic [511:0] blk;
      build_expected();
      nw = exp_w.size();
      nblk = nw / 16;
      wr0 = wr_log.size(); go0 = go_cnt; in0 = init_cnt; dv0 = dv_cnt; vi0 = viol_cnt;
      send_bytes(toggle, gap_max);
      t = 0;
      while (dv_cnt == dv0 && t < 3000) begin
         @(posedge clk); #1; t++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk_int({tag, " digest_valid pulses"}, dv_cnt - dv0, 1);
      chk_int({tag, " write count"}, wr_log.size() - wr0, nw);
      for (int i = 0; i < nw && wr0 + i < wr_log.size(); i++)
         chk_vec($sformatf("%s write %0d", tag, i), 256'(wr_log[wr0 + i]),
                 256'({4'(i % 16), exp_w[i]}));
      chk_int({tag, " go count"}, go_cnt - go0, (exp_gos >= 0) ? exp_gos : nblk);
      chk_int({tag, " init count"}, init_cnt - in0, 1);
      chk_int({tag, " protocol violations"}, viol_cnt - vi0, 0);
      chk_int({tag, " busy after fin"}, int'(busy), 0);
      h = IV;
      for (int bi = 0; bi < nblk; bi++) begin
         for (int j = 0; j < 16; j++) blk[511 - 32*j -: 32] = exp_w[16*bi + j];
         h = sha_compress(h, blk);
      end
      chk_vec({tag, " digest"}, core_h, h);
`ifdef SHA256_BLOCK_COUNT_EN
      chk_int({tag, " block_count"}, int'(block_count), nblk);
`endif
   endtask

   typedef struct {
      int          len;
      logic [7:0]  first;
      bit          inc;
      bit          toggle;
      int          exp_gos;
      int          chk_idx;
      logic [31:0] chk_val;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int base, go0, dv0, t;
      logic [31:0] got;
      vecs[0] = '{55, 8'h61, 1'b0, 1'b0, 1, 13, 32'h61616180};
      vecs[1] = '{55, 8'h61, 1'b0, 1'b0, 1, 15, 32'h000001B8};
      vecs[2] = '{56, 8'h61, 1'b0, 1'b0, 2, 14, 32'h80000000};
      vecs[3] = '{56, 8'h61, 1'b0, 1'b0, 2, 15, 32'h00000000};
      vecs[4] = '{56, 8'h61, 1'b0, 1'b0, 2, 29, 32'h00000000};
      vecs[5] = '{56, 8'h61, 1'b0, 1'b0, 2, 31, 32'h000001C0};
      vecs[6] = '{64, 8'h00, 1'b1, 1'b1, 2, 5, 32'h14151617};
      vecs[7] = '{64, 8'h00, 1'b1, 1'b1, 2, 16, 32'h80000000};
      vecs[8] = '{64, 8'h00, 1'b1, 1'b1, 2, 31, 32'h00000200};

      repeat (3) @(posedge clk);
      #1;
      chk_vec("reset outputs", 256'({in_ready, core_init, core_cs, core_wr, core_addr, core_wdata,
                                     core_go, busy, digest_valid}), 256'(0));
      reset = 1'b0;
      @(posedge clk); #1;

      // "abc"
      msg_q = '{8'h61, 8'h62, 8'h63};
      base = wr_log.size();
      run_msg("abc", 1'b0, 0, 1);
      chk_vec("abc word0", 256'(wr_log[base][31:0]), 256'(32'h61626380));
      chk_vec("abc h0", 256'(core_h[255:224]), 256'(32'hba7816bf));
      chk_vec("abc h7", 256'(core_h[31:0]), 256'(32'hf20015ad));

      for (int v = 0; v < 9; v++) begin
         msg_q.delete();
         for (int i = 0; i < vecs[v].len; i++)
            msg_q.push_back(vecs[v].inc ? vecs[v].first + 8'(i) : vecs[v].first);
         base = wr_log.size();
         run_msg($sformatf("vec%0d", v), vecs[v].toggle, 0, vecs[v].exp_gos);
         got = (base + vecs[v].chk_idx < wr_log.size()) ? wr_log[base + vecs[v].chk_idx][31:0]
                                                       : 32'hxxxxxxxx;
         chk_vec($sformatf("vec%0d word %0d", v, vecs[v].chk_idx), 256'(got),
                 256'(vecs[v].chk_val));
      end

      // Reset while waiting for the first block of a two-block message.
      msg_q.delete();
      for (int i = 0; i < 56; i++) msg_q.push_back(8'h41);
      go0 = go_cnt;
      dv0 = dv_cnt;
      send_bytes(1'b0, 0);
      t = 0;
      while (go_cnt == go0 && t < 200) begin
         @(posedge clk); #1; t++;
      end
      chk_int("abort first go", go_cnt - go0, 1);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk_vec("abort outputs", 256'({in_ready, core_init, core_cs, core_wr, core_addr, core_wdata,
                                     core_go, busy, digest_valid}), 256'(0));
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      chk_int("abort no further go", go_cnt - go0, 1);
      chk_int("abort no digest", dv_cnt - dv0, 0);

      msg_q = '{8'h61, 8'h62, 8'h63};
      run_msg("abc after abort", 1'b0, 0, 1);
      chk_vec("abc after abort h0", 256'(core_h[255:224]), 256'(32'hba7816bf));

      for (int r = 0; r < 12; r++) begin
         msg_q.delete();
         for (int i = 0; i < int'($urandom_range(150, 1)); i++) msg_q.push_back(8'($urandom));
         run_msg($sformatf("rand%0d len%0d", r, msg_q.size()), 1'b0, int'($urandom_range(2)), -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL global timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sha256_msg_feeder.md
Name: sha256_msg_feeder

Overview:
- Host-side initiator for the SHA-256 compression core. Accepts a byte stream, packs bytes big-endian into 32-bit words and performs SHA-256 padding: 0x80, zero fill and the 64-bit bit length.
- Drives the core's write port (chipselect/write/address/writedata), pulses go once per 512-bit block and waits for done.
- Signals digest_valid when the core's h0..h7 hold the final digest.

Parameters:
- CNT_W, 32: width of the internal message byte counter. The bit-length field is {CNT_W+3 bits of byte_count<<3}, zero-extended to 64 bits.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_data  in  8  message byte
- in_valid  in  1  byte valid
- in_last  in  1  byte is the final byte of the message; qualified by in_valid
- in_ready  out  1  byte accepted when in_valid && in_ready
- core_init  out  1  one-cycle pulse driving the core's reset; reloads the IV
- core_cs  out  1  core chipselect; equals core_wr
- core_wr  out  1  core write strobe
- core_addr  out  4  word index 0..15
- core_wdata  out  32  word data
- core_go  out  1  one-cycle start pulse
- core_done  in  1  core done level
- busy  out  1  high in any state except IDLE
- digest_valid  out  1  one-cycle pulse; the core's h0..h7 are final

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; byte_count, word_idx and the byte lane all 0.
  - Reset mid-operation aborts immediately; no further go or write is issued.
- Zero-length messages are not supported. A message is one or more bytes; in_last marks the final byte.
- IDLE: in_ready=0. On in_valid, go to INIT.
- INIT: core_init=1 for exactly 1 cycle, then LOAD. No core write occurs in the same cycle as core_init.
- LOAD:
  - in_ready=1.
  - Each accepted byte is shifted into the word register: first byte to bits 31:24, last to bits 7:0. byte_count increments and wraps silently at 2^CNT_W.
  - When the 4th byte of a word is accepted at cycle T, at T+1 assert core_cs=core_wr=1, core_addr=word_idx, core_wdata=word. word_idx then increments.
  - If that write was word 15, in_ready=0 from T+1 and the next state is GO.
  - If in_last is accepted, go to PAD (in_ready=0), carrying the lane position. in_last on a word-completing byte issues that word's write first.
- PAD: emits one write per cycle:
  - First padding word: the partial word with 0x80 in the next lane and zeros below it, or 0x80000000 if the last byte completed a word.
  - Then zeros up to index 13.
  - Index 14 = length[63:32], index 15 = length[31:0], where length = byte_count*8.
  - If the 0x80 word lands at index 14 or 15, zero-fill to 15 without the length and set extra_block. The following block is zeros 0..13 plus the length at 14..15.
- GO: core_go=1 for 1 cycle, at least one cycle after the last write of the block. Then WAIT0.
- WAIT0: one cycle, ignoring core_done because the core drops done one cycle after go. Then WAIT.
- WAIT: hold until core_done=1, then:
  - to LOAD with word_idx=0 if the message is unfinished;
  - to PAD if extra_block is set;
  - otherwise to FIN.
- FIN: digest_valid=1 for one cycle, then IDLE.
- Back-to-back messages: a new message is accepted only in IDLE. in_valid during FIN waits.
- in_valid gaps are permitted anywhere in LOAD. The state is held and no write is issued.

Optional Feature:
- Macro SHA256_BLOCK_COUNT_EN.
- Defined:
  - Adds output block_count[15:0], reset 0.
  - Cleared in INIT; increments on each core_go and saturates at 0xFFFF.
  - Holds its value after FIN until the next INIT.
- Undefined: the port and its logic are absent.

Test Plan:
- "abc" (0x61,0x62,0x63 with last): exactly one core_init and one core_go. Word0=0x61626380, words 1..14=0, word15=0x00000018. After digest_valid, core h0=0xba7816bf and h7=0xf20015ad.
- 55 bytes of 0x61: single block. Word13=0x61616180, word14=0, word15=0x000001B8. One go.
- 56 bytes of 0x61: two gos. Block 1 word14=0x80000000, word15=0. Block 2 words 0..13=0, word15=0x000001C0.
- 64 bytes with in_valid toggled every other cycle: the first block's 16 writes carry the data unchanged. Block 2 word0=0x80000000, word15=0x00000200. No write during in_valid=0 cycles.
- Reset asserted in WAIT of a 2-block message: all outputs 0 next cycle, with no further go or digest_valid. A following "abc" message produces the correct digest.
- With SHA256_BLOCK_COUNT_EN: the 56-byte message gives block_count=2, and the "abc" message gives block_count=1.
